async_reset_reg_pipe: RTL and testbench

//   Parametrised elastic register pipeline with asynchronous active-low reset; next generation of the single-bit async-reset register.
//   - Carries DATA_WIDTH-bit words through DEPTH register stages using valid/ready handshakes.
//   - Bubble-collapsing: empty stages accept data even while downstream stalls.
//   - Used for timing closure on long handshaked paths and for reset-safe retiming.

---
 rtl/async_reg_pipe_pkg.sv | 32 +++
 rtl/async_reg_pipe_stage.sv | 51 +++++
 rtl/async_reset_reg_pipe.sv | 92 +++++++++
 tb/tb_async_reset_reg_pipe.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_reg_pipe_pkg.sv
// Shared types and helpers for the async-reset elastic register pipeline.
// Consumers import async_reg_pipe_pkg::* for occupancy sizing and update decoding.
package async_reg_pipe_pkg;

    localparam int DEPTH_MIN = 1;

    typedef enum logic [1:0] {
        OCC_HOLD,
        OCC_INC,
        OCC_DEC,
        OCC_CLR
    } occ_op_e;

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Clear dominates; simultaneous in and out transfers cancel.
    function automatic occ_op_e occ_op(input logic in_xfer, input logic out_xfer, input logic clr);
        if (clr) begin
            return OCC_CLR;
        end
        if (in_xfer && !out_xfer) begin
            return OCC_INC;
        end
        if (out_xfer && !in_xfer) begin
            return OCC_DEC;
        end
        return OCC_HOLD;
    endfunction

endpackage

// File: rtl/async_reg_pipe_stage.sv
// One valid/data register pair of the elastic pipeline, asynchronously reset to INIT_VAL.
// The stage accepts whenever it is empty or its own content is moving downstream.
module async_reg_pipe_stage #(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  vld_in,
    input  logic [DATA_WIDTH-1:0] dat_in,
    input  logic                  rdy_in,
    output logic                  rdy_out,
    output logic                  vld_out,
    output logic [DATA_WIDTH-1:0] dat_out
);

    logic                  vld_q;
    logic                  vld_d;
    logic [DATA_WIDTH-1:0] dat_q;
    logic [DATA_WIDTH-1:0] dat_d;

    assign rdy_out = ~vld_q | rdy_in;
    assign vld_out = vld_q;
    assign dat_out = dat_q;

    // A bubble passing through leaves the data register untouched.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (clr) begin
            vld_d = 1'b0;
        end else if (rdy_out) begin
            vld_d = vld_in;
            if (vld_in) begin
                dat_d = dat_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            dat_q <= INIT_VAL;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

endmodule

// File: rtl/async_reset_reg_pipe.sv
// Bubble-collapsing valid/ready register pipeline of DEPTH stages with async active-low reset.
// Optional synchronous flush port enabled by defining ASYNC_REG_PIPE_FLUSH_EN.
module async_reset_reg_pipe
    import async_reg_pipe_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    DEPTH      = 2,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_WIDTH-1:0]    din,
    input  logic                     din_vld,
    output logic                     din_rd,
    output logic [DATA_WIDTH-1:0]    dout,
    output logic                     dout_vld,
    input  logic                     dout_rd,
    output logic [occ_w(DEPTH)-1:0]  occupancy
`ifdef ASYNC_REG_PIPE_FLUSH_EN
    ,
    input  logic                     flush
`endif
);

    localparam int OW = occ_w(DEPTH);

    // Index i of each chain is the input side of stage i; index DEPTH is the pipe output.
    logic                  rdy       [DEPTH+1];
    logic                  vld_chain [DEPTH+1];
    logic [DATA_WIDTH-1:0] dat_chain [DEPTH+1];

    logic          clr;
    logic          in_xfer;
    logic          out_xfer;
    logic [OW-1:0] occ_q;
    logic [OW-1:0] occ_d;

`ifdef ASYNC_REG_PIPE_FLUSH_EN
    assign clr = flush;
`else
    assign clr = 1'b0;
`endif

    assign rdy[DEPTH]    = dout_rd;
    assign vld_chain[0]  = din_vld;
    assign dat_chain[0]  = din;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        async_reg_pipe_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .INIT_VAL   (INIT_VAL)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (clr),
            .vld_in  (vld_chain[gi]),
            .dat_in  (dat_chain[gi]),
            .rdy_in  (rdy[gi+1]),
            .rdy_out (rdy[gi]),
            .vld_out (vld_chain[gi+1]),
            .dat_out (dat_chain[gi+1])
        );
    end

    assign din_rd   = rdy[0] & ~clr;
    assign dout     = dat_chain[DEPTH];
    assign dout_vld = vld_chain[DEPTH];

    assign in_xfer  = din_vld & din_rd;
    assign out_xfer = dout_vld & dout_rd;

    always_comb begin
        occ_d = occ_q;
        case (occ_op(in_xfer, out_xfer, clr))
            OCC_CLR: occ_d = '0;
            OCC_INC: occ_d = occ_q + OW'(1);
            OCC_DEC: occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_async_reset_reg_pipe.sv
// Self-checking bench: a DEPTH=2 and a DEPTH=3 pipeline driven by directed tables,
// hand sequences and a randomized queue-based reference model.
module tb_async_reset_reg_pipe;

    localparam logic [7:0] INIT = 8'hA5;

    logic       clk;
    logic       rst_n;

    logic [7:0] d2_din;
    logic       d2_din_vld;
    logic       d2_din_rd;
    logic [7:0] d2_dout;
    logic       d2_dout_vld;
    logic       d2_dout_rd;
    logic [1:0] d2_occ;

    logic [7:0] d3_din;
    logic       d3_din_vld;
    logic       d3_din_rd;
    logic [7:0] d3_dout;
    logic       d3_dout_vld;
    logic       d3_dout_rd;
    logic [1:0] d3_occ;

`ifdef ASYNC_REG_PIPE_FLUSH_EN
    logic       d2_flush;
    logic       d3_flush;
`endif

    int n_chk;
    int n_fail;

    async_reset_reg_pipe #(.DATA_WIDTH(8), .DEPTH(2), .INIT_VAL(INIT)) u_d2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (d2_din),
        .din_vld   (d2_din_vld),
        .din_rd    (d2_din_rd),
        .dout      (d2_dout),
        .dout_vld  (d2_dout_vld),
        .dout_rd   (d2_dout_rd),
        .occupancy (d2_occ)
`ifdef ASYNC_REG_PIPE_FLUSH_EN
        ,
        .flush     (d2_flush)
`endif
    );

    async_reset_reg_pipe #(.DATA_WIDTH(8), .DEPTH(3), .INIT_VAL(INIT)) u_d3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (d3_din),
        .din_vld   (d3_din_vld),
        .din_rd    (d3_din_rd),
        .dout      (d3_dout),
        .dout_vld  (d3_dout_vld),
        .dout_rd   (d3_dout_rd),
        .occupancy (d3_occ)
`ifdef ASYNC_REG_PIPE_FLUSH_EN
        ,
        .flush     (d3_flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        d2_din = '0; d2_din_vld = 1'b0; d2_dout_rd = 1'b0;
        d3_din = '0; d3_din_vld = 1'b0; d3_dout_rd = 1'b0;
`ifdef ASYNC_REG_PIPE_FLUSH_EN
        d2_flush = 1'b0; d3_flush = 1'b0;
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct packed {
        logic [7:0] din;
        logic       din_vld;
        logic       dout_rd;
        logic       exp_din_rd;
        logic       exp_dout_vld;
        logic [7:0] exp_dout;
        logic [1:0] exp_occ;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        int         c;
    } ent_t;

    vec_t stream_tbl [6];
    ent_t q [$];

    initial begin
        logic [7:0] words [4];
        n_chk  = 0;
        n_fail = 0;
        idle_inputs();
        rst_n = 1'b1;

        // DEPTH=2 streaming 0x11,0x22,0x33 with the consumer always ready
        stream_tbl[0] = '{8'h11, 1'b1, 1'b1, 1'b1, 1'b0, INIT,  2'd0};
        stream_tbl[1] = '{8'h22, 1'b1, 1'b1, 1'b1, 1'b0, INIT,  2'd1};
        stream_tbl[2] = '{8'h33, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 2'd2};
        stream_tbl[3] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h22, 2'd2};
        stream_tbl[4] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h33, 2'd1};
        stream_tbl[5] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h33, 2'd0};

        // Power-on reset
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_d2_dout_vld", d2_dout_vld, 1'b0);
        chk("rst_d2_dout",     d2_dout,     INIT);
        chk("rst_d2_din_rd",   d2_din_rd,   1'b1);
        chk("rst_d2_occ",      d2_occ,      2'd0);
        chk("rst_d3_dout_vld", d3_dout_vld, 1'b0);
        chk("rst_d3_dout",     d3_dout,     INIT);
        chk("rst_d3_occ",      d3_occ,      2'd0);
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            d2_din     = stream_tbl[i].din;
            d2_din_vld = stream_tbl[i].din_vld;
            d2_dout_rd = stream_tbl[i].dout_rd;
            #1;
            chk("stream_din_rd",   d2_din_rd,   stream_tbl[i].exp_din_rd);
            chk("stream_dout_vld", d2_dout_vld, stream_tbl[i].exp_dout_vld);
            chk("stream_dout",     d2_dout,     stream_tbl[i].exp_dout);
            chk("stream_occ",      d2_occ,      stream_tbl[i].exp_occ);
            $display("stream vec %0d: din=0x%0h vld=%0b -> dout=0x%0h dout_vld=%0b occ=%0d",
                     i, d2_din, d2_din_vld, d2_dout, d2_dout_vld, d2_occ);
            tick();
        end
        idle_inputs();

        // DEPTH=3 backpressure: 3 of 4 words fit, the 4th enters on the single ready cycle
        do_reset();
        words[0] = 8'h31; words[1] = 8'h32; words[2] = 8'h33; words[3] = 8'h34;
        d3_dout_rd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d3_din     = words[i];
            d3_din_vld = 1'b1;
            #1;
            chk("bp_din_rd", d3_din_rd, (i < 3));
            $display("bp offer 0x%0h din_rd=%0b occ=%0d", d3_din, d3_din_rd, d3_occ);
            if (i < 3) tick();
        end
        chk("bp_full_occ",  d3_occ,      2'd3);
        chk("bp_full_vld",  d3_dout_vld, 1'b1);
        chk("bp_full_dout", d3_dout,     8'h31);
        d3_dout_rd = 1'b1;
        #1;
        chk("bp_release_din_rd", d3_din_rd, 1'b1);
        tick();
        d3_dout_rd = 1'b0;
        d3_din_vld = 1'b0;
        #1;
        chk("bp_shift_occ",  d3_occ,  2'd3);
        chk("bp_shift_dout", d3_dout, 8'h32);
        tick();
        for (int k = 1; k < 4; k++) begin
            d3_dout_rd = 1'b1;
            #1;
            chk("bp_drain_vld",  d3_dout_vld, 1'b1);
            chk("bp_drain_dout", d3_dout,     words[k]);
            $display("bp drain 0x%0h", d3_dout);
            tick();
        end
        d3_dout_rd = 1'b0;
        #1;
        chk("bp_empty_vld", d3_dout_vld, 1'b0);
        chk("bp_empty_occ", d3_occ,      2'd0);

        // DEPTH=3 bubble collapse: one stalled word in the last stage, new word still enters
        do_reset();
        d3_din = 8'h61; d3_din_vld = 1'b1;
        tick();
        d3_din_vld = 1'b0;
        tick();
        tick();
        d3_din = 8'h62; d3_din_vld = 1'b1;
        #1;
        chk("bubble_dout_vld", d3_dout_vld, 1'b1);
        chk("bubble_dout",     d3_dout,     8'h61);
        chk("bubble_occ1",     d3_occ,      2'd1);
        chk("bubble_din_rd",   d3_din_rd,   1'b1);
        tick();
        d3_din_vld = 1'b0;
        #1;
        chk("bubble_occ2",       d3_occ,  2'd2);
        chk("bubble_dout_stall", d3_dout, 8'h61);
        $display("bubble: accepted 0x62 behind stalled 0x61, occ=%0d", d3_occ);

        // DEPTH=3 asynchronous reset with the pipe full and a word on offer
        do_reset();
        for (int i = 0; i < 3; i++) begin
            d3_din = 8'h41 + 8'(i); d3_din_vld = 1'b1;
            tick();
        end
        d3_din = 8'h44;
        #1;
        chk("arst_pre_occ",    d3_occ,    2'd3);
        chk("arst_pre_din_rd", d3_din_rd, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_dout_vld", d3_dout_vld, 1'b0);
        chk("arst_dout",     d3_dout,     INIT);
        chk("arst_occ",      d3_occ,      2'd0);
        chk("arst_din_rd",   d3_din_rd,   1'b1);
        tick();
        rst_n = 1'b1;
        d3_din = 8'h55; d3_din_vld = 1'b1; d3_dout_rd = 1'b1;
        #1;
        chk("arst_first_din_rd", d3_din_rd, 1'b1);
        tick();
        d3_din_vld = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            #1;
            chk("arst_latency_vld", d3_dout_vld, (j == 3));
            if (j == 3) chk("arst_latency_dout", d3_dout, 8'h55);
            tick();
        end

`ifdef ASYNC_REG_PIPE_FLUSH_EN
        // DEPTH=2 flush while full, with a competing input word and a ready consumer
        do_reset();
        for (int i = 0; i < 2; i++) begin
            d2_din = 8'h71 + 8'(i); d2_din_vld = 1'b1;
            tick();
        end
        d2_din = 8'h73; d2_din_vld = 1'b1; d2_dout_rd = 1'b1; d2_flush = 1'b1;
        #1;
        chk("flush_din_rd", d2_din_rd, 1'b0);
        tick();
        d2_flush = 1'b0; d2_din_vld = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            chk("flush_dout_vld", d2_dout_vld, 1'b0);
            chk("flush_occ",      d2_occ,      2'd0);
            tick();
        end
        $display("flush: pipe emptied, offered word 0x73 dropped");
`endif

        // DEPTH=3 random traffic against a queue model. The oldest word in flight never
        // waits behind anything, so it is at the output exactly DEPTH cycles after entry.
        do_reset();
        q.delete();
        begin
            int  n_out;
            logic fl;
            logic exp_rd;
            logic exp_ov;
            logic inx;
            logic outx;
            ent_t e;
            n_out = 0;
            for (int n = 0; n < 10000; n++) begin
                if (!d3_din_vld && $urandom_range(0, 3) != 0) begin
                    d3_din_vld = 1'b1;
                    d3_din     = 8'($urandom);
                end
                d3_dout_rd = ($urandom_range(0, 99) < (((n / 500) % 2 == 1) ? 30 : 85));
                fl = 1'b0;
`ifdef ASYNC_REG_PIPE_FLUSH_EN
                d3_flush = ($urandom_range(0, 63) == 0);
                fl = d3_flush;
`endif
                #1;
                exp_rd = !fl && ((q.size() < 3) || d3_dout_rd);
                exp_ov = (q.size() > 0) && ((n - q[0].c) >= 3);
                chk("rand_din_rd",   d3_din_rd,   exp_rd);
                chk("rand_dout_vld", d3_dout_vld, exp_ov);
                chk("rand_occ",      d3_occ,      q.size());
                if (exp_ov) chk("rand_dout", d3_dout, q[0].d);
                inx  = d3_din_vld && exp_rd;
                outx = exp_ov && d3_dout_rd && !fl;
                if (fl) begin
                    q.delete();
                end else begin
                    if (outx) begin
                        void'(q.pop_front());
                        n_out++;
                    end
                    if (inx) begin
                        e.d = d3_din;
                        e.c = n;
                        q.push_back(e);
                    end
                end
                tick();
                if (inx) d3_din_vld = 1'b0;
            end
            $display("random: %0d words delivered, %0d left in flight", n_out, q.size());
        end

        idle_inputs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
